bit_serial_alu: RTL and testbench

- Bit-serial 8-bit ALU datapath stage that consumes the one-bit gate primitives (AND, OR, NOT, XOR) and drives a single full-adder bit slice, LSB first, one bit per clock.
- Accepts an operand pair plus opcode over a valid/ready handshake and shifts the operands through the 1-bit slice.
- Presents the full-width result, carry and zero flags on a valid/ready output port.
- Sits between the register/operand source and the result writeback stage.

---
 rtl/bit_serial_alu_if.sv | 35 +++
 rtl/bit_serial_alu.sv | 120 ++++++++++++
 tb/tb_bit_serial_alu.sv | 115 +++++++++++
 3 files changed

// File: rtl/bit_serial_alu_if.sv
// Operand/result handshake bundle for bit_serial_alu.
// BSALU_OVERFLOW_EN adds the signed-overflow flag to the result side.
interface bit_serial_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
`ifdef BSALU_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, zero
`ifdef BSALU_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, zero
`ifdef BSALU_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one full-adder/logic slice, LSB first, one bit per clock.
// Optional signed overflow flag when BSALU_OVERFLOW_EN is defined.
module bit_serial_alu #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  bit_serial_alu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [WIDTH-2:0] sr_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, carry_q, zero_q, in_ready_q, out_valid_q;
`ifdef BSALU_OVERFLOW_EN
  logic             ovf_q;
`endif

  logic             a0, b0, arith, sum, cout, bit_d, last;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    a0    = a_q[0];
    b0    = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
    arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    sum   = a0 ^ b0 ^ c_q;
    cout  = (a0 & b0) | (c_q & (a0 ^ b0));
    case (op_q)
      OP_AND:  bit_d = a0 & b0;
      OP_OR:   bit_d = a0 | b0;
      OP_XOR:  bit_d = a0 ^ b0;
      OP_NAND: bit_d = ~(a0 & b0);
      OP_ADD,
      OP_SUB:  bit_d = sum;
      OP_NOT:  bit_d = ~a0;
      default: bit_d = a0;
    endcase
    // New bit enters at the MSB so the LSB-first stream lands aligned after WIDTH shifts
    sr_d = {bit_d, sr_q};
    last = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sr_q        <= '0;
      res_q       <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef BSALU_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q        <= bus.a;
          b_q        <= bus.b;
          op_q       <= bus.op;
          c_q        <= (bus.op == OP_SUB);
          cnt_q      <= '0;
          in_ready_q <= 1'b0;
          state_q    <= SHIFT;
        end
        SHIFT: begin
          sr_q  <= sr_d[WIDTH-1:1];
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (arith) c_q <= cout;
          if (last) begin
            res_q       <= sr_d;
            carry_q     <= arith & cout;
            zero_q      <= (sr_d == '0);
`ifdef BSALU_OVERFLOW_EN
            // carry into MSB is c_q, carry out of MSB is cout
            ovf_q       <= arith & (c_q ^ cout);
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
`ifdef BSALU_OVERFLOW_EN
  assign bus.overflow  = ovf_q;
`endif
endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed bench for bit_serial_alu: latency, flags, backpressure, mid-op reset.
module tb_bit_serial_alu;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  bit_serial_alu_if #(.WIDTH(WIDTH)) bus ();

  bit_serial_alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] er, input logic ec,
                       input logic ez, input logic eo, input int hold);
    bus.op = o; bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
    chk({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    // scramble inputs after acceptance; they must not matter
    bus.in_valid = 1'b0; bus.a = ~av; bus.b = 8'($urandom); bus.op = ~o;
    chk({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
    repeat (WIDTH - 1) @(posedge clk);
    #1;
    chk({tag, " out_valid early"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " result"}, 32'(bus.result), 32'(er));
    chk({tag, " carry"}, 32'(bus.carry), 32'(ec));
    chk({tag, " zero"}, 32'(bus.zero), 32'(ez));
`ifdef BSALU_OVERFLOW_EN
    chk({tag, " overflow"}, 32'(bus.overflow), 32'(eo));
`else
    if (eo === 1'bx) $display("unused overflow arg");
`endif
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = ~bus.in_valid; bus.a = 8'($urandom); bus.b = 8'($urandom);
      @(posedge clk); #1;
      chk({tag, " hold result"}, 32'(bus.result), 32'(er));
      chk({tag, " hold carry"}, 32'(bus.carry), 32'(ec));
      chk({tag, " hold zero"}, 32'(bus.zero), 32'(ez));
      chk({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    chk({tag, " back to idle in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, " back to idle out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst result", 32'(bus.result), 32'd0);
    chk("rst carry", 32'(bus.carry), 32'd0);
    chk("rst zero", 32'(bus.zero), 32'd0);
`ifdef BSALU_OVERFLOW_EN
    chk("rst overflow", 32'(bus.overflow), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    //     tag         op      a      b      res    c     z     ovf   hold
    do_op("add ff+01", 3'b100, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    do_op("add 7f+01", 3'b100, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 0);
    do_op("sub 05-07", 3'b101, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 0);
    do_op("sub 07-05", 3'b101, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0, 0);
    do_op("sub 80-01", 3'b101, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 0);
    do_op("xor",       3'b010, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0, 1'b0, 0);
    do_op("and",       3'b000, 8'hF0, 8'hCC, 8'hC0, 1'b0, 1'b0, 1'b0, 0);
    do_op("and zero",  3'b000, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    do_op("nand",      3'b011, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0, 1'b0, 0);
    do_op("or",        3'b001, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0, 0);
    do_op("not",       3'b110, 8'h0F, 8'h55, 8'hF0, 1'b0, 1'b0, 1'b0, 0);
    do_op("pass",      3'b111, 8'h3C, 8'hFF, 8'h3C, 1'b0, 1'b0, 1'b0, 0);
    do_op("backpress", 3'b100, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 5);

    // reset asserted across the 3rd SHIFT edge
    bus.op = 3'b100; bus.a = 8'hFF; bus.b = 8'hFF; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst result", 32'(bus.result), 32'd0);
    chk("midrst carry", 32'(bus.carry), 32'd0);
    chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (WIDTH) @(posedge clk);
    #1;
    chk("midrst stays idle", 32'(bus.out_valid), 32'd0);
    do_op("add after rst", 3'b100, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
